mips_muldiv_seq: RTL
====================

# mips_muldiv_seq

Multi-cycle sequencer for the MIPS HI/LO secondary ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the control unit's `sec_alu_en`/`sec_alu_op` outputs. It runs an iterative 32-step shift-add multiply or restoring divide, and owns the HI/LO registers. It raises a stall to the pipeline whenever a new secondary-ALU request arrives while an operation is in flight.

## Interface
Parameters:
- `ITER`, 32: iteration count, equal to the operand width; fixed at 32 for this core.

Ports:
- `i_clk`  in  1  core clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_en`  in  1  secondary-ALU request, driven by the CU `sec_alu_en`
- `i_op`  in  3  op code: 000 mfhi, 010 mflo, 001 mthi, 011 mtlo, 100 mult, 101 multu, 110 div, 111 divu
- `i_a`  in  32  rs operand: multiplicand, dividend, or mthi/mtlo data
- `i_b`  in  32  rt operand: multiplier or divisor
- `i_flush`  in  1  exception flush; aborts the in-flight op
- `o_busy`  out  1  mul/div in progress
- `o_stall`  out  1  combinational: `i_en & o_busy & ~i_flush`
- `o_result`  out  32  combinational: HI when `i_op[1]==0`, else LO
- `o_hi`, `o_lo`  out  32 each  architectural HI/LO (debug/coprocessor visibility)

## Operation
- States: IDLE, MUL, DIV, FIX.
- Request acceptance:
  - A request is accepted in IDLE when `i_en & ~i_flush`.
  - In MUL, DIV or FIX, any request stalls (`o_stall=1`) and is not accepted. The pipeline holds `i_en`, `i_op` and the operands stable until it is accepted.
- Accepted ops:
  - mthi: HI←`i_a` at the clock edge.
  - mtlo: LO←`i_a` at the clock edge.
  - mfhi/mflo: pure read via `o_result`; no state change.
  - mult/multu: latch operand magnitudes (absolute values for signed) and the result sign; counter←0; →MUL.
  - div/divu: latch magnitudes, quotient sign (`a[31]^b[31]`, signed only) and remainder sign (`a[31]`, signed only); →DIV.
- MUL: one shift-add step per cycle on a 64-bit accumulator. After `ITER` steps →FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After `ITER` steps →FIX.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - mult: {HI,LO}←64-bit product.
  - div: LO←quotient, truncated toward zero; HI←remainder, carrying the sign of the dividend.
  - →IDLE.
- Arithmetic corner cases:
  - Divisor = 0, signed or unsigned: LO=32'hFFFFFFFF, HI=`i_a`, normal latency, no exception.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Flush:
  - `i_flush` in any state →IDLE next cycle; HI/LO unchanged.
  - `i_flush` together with an `i_en` in IDLE: the request is dropped, including mthi/mtlo.
- Reset: HI=LO=0, state IDLE, counter 0, `o_busy=0`. Reset has priority over flush and requests, including mid-operation.

## Timing
- Cycle 0 is the cycle in which mult/div is accepted.
- `o_busy` is high in cycles 1..33: 32 iteration cycles plus 1 FIX cycle.
- HI/LO are updated at the end of cycle 33. `o_busy` is 0 and new HI/LO are visible on `o_result`, `o_hi` and `o_lo` from cycle 34.
- Back-to-back:
  - A mult/div requested in cycle 34 is accepted in cycle 34.
  - An mfhi/mflo stalled during busy is served combinationally in cycle 34.
- mthi/mtlo in IDLE: the new value is visible on `o_result` the next cycle.
- `o_stall` is combinational from `i_en`/`i_flush` and registered `o_busy`; there is no other combinational input→output path except `o_result` mux select by `i_op`.
- Reset values: `o_busy=0`, `o_hi=0`, `o_lo=0`. `o_result=0`. `o_stall=0`.

## Test plan
- multu with `i_a=i_b=32'hFFFFFFFF` → `o_busy` high for exactly 33 cycles; cycle 34: HI=FFFFFFFE, LO=00000001.
- mult −3×7 → HI=FFFFFFFF, LO=FFFFFFEB. div −7/2 → LO=FFFFFFFD, HI=FFFFFFFF. divu 7/2 → LO=3, HI=1.
- div 5/0 → LO=FFFFFFFF, HI=5. div 0x80000000/0xFFFFFFFF → LO=80000000, HI=0; both at cycle 34.
- mult 6×7 then `i_en`/mflo held from cycle 5 → `o_stall=1` cycles 5..33; cycle 34: `o_stall=0`, `o_result=42`.
- mthi 0x12345678, mtlo 0xCAFEBABE, then div 100/3 with `i_flush` at cycle 10 → `o_busy=0` at cycle 11; HI/LO keep 12345678/CAFEBABE. Simultaneous `i_flush`+mtlo 0x1 → LO unchanged.
- `i_rst` asserted at cycle 20 of a mult → next cycle HI=LO=0, `o_busy=0`; a new multu 2×3 then completes normally with LO=6.

Source files
------------

// File: rtl/mips_muldiv_seq.sv
// Iterative HI/LO secondary ALU for the MIPS core: 32-step shift-add multiply,
// 32-step restoring divide, sign fix-up cycle, and the architectural HI/LO pair.
module mips_muldiv_seq #(
   parameter int ITER = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_stall,
   output logic [31:0] o_result,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [63:0]   acc_q;
   logic [31:0]   opnd_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          is_div_q;
   logic          neg_q;
   logic          neg_rem_q;
   logic          dz_q;
   logic          busy_q;

   // Signed ops have i_op[0]==0; operands are reduced to magnitudes up front.
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   assign a_neg = ~i_op[0] & i_a[31];
   assign b_neg = ~i_op[0] & i_b[31];
   assign a_mag = a_neg ? -i_a : i_a;
   assign b_mag = b_neg ? -i_b : i_b;

   // Multiply: low half holds the multiplier, consumed one bit per step.
   logic [32:0] mul_sum;
   logic [63:0] mul_acc_d;
   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_acc_d = {mul_sum, acc_q[31:1]};

   // Divide: acc = {remainder, dividend/quotient}; a borrow means restore.
   logic [32:0] div_shift, div_trial;
   logic [63:0] div_acc_d;
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign div_trial = div_shift - {1'b0, opnd_q};
   assign div_acc_d = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_trial[31:0], acc_q[30:0], 1'b1};

   logic [63:0] prod_d;
   logic [31:0] quo_d, rem_d;
   assign prod_d = neg_q ? -acc_q : acc_q;
   assign quo_d  = dz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
   assign rem_d  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else if (i_flush) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_en) begin
                  case (i_op)
                     3'b001: hi_q <= i_a;
                     3'b011: lo_q <= i_a;
                     3'b100, 3'b101: begin
                        acc_q    <= {32'd0, b_mag};
                        opnd_q   <= a_mag;
                        neg_q    <= a_neg ^ b_neg;
                        is_div_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL;
                     end
                     3'b110, 3'b111: begin
                        acc_q     <= {32'd0, a_mag};
                        opnd_q    <= b_mag;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dz_q      <= (i_b == 32'd0);
                        is_div_q  <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= DIV;
                     end
                     default: ;
                  endcase
               end
            end
            MUL: begin
               acc_q <= mul_acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
            end
            DIV: begin
               acc_q <= div_acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
            end
            FIX: begin
               if (is_div_q) begin
                  hi_q <= rem_d;
                  lo_q <= quo_d;
               end else begin
                  {hi_q, lo_q} <= prod_d;
               end
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_busy   = busy_q;
   assign o_stall  = i_en & busy_q & ~i_flush;
   assign o_result = i_op[1] ? lo_q : hi_q;
   assign o_hi     = hi_q;
   assign o_lo     = lo_q;

endmodule
